// File: rtl/signmag_add.sv
// Bit-serial sign-magnitude restore: X = Y + (neg ? -Res : Res), one bit per cycle, LSB first.
// Optional build macro SIGNMAG_ADD_SAT_EN clamps X to 0 / 2^n-1 when ovf is raised.
module signmag_add #(
    parameter int n = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [n-1:0] Res,
    input  logic         neg,
    input  logic [n-1:0] Y,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [n-1:0] X,
    output logic         ovf
);

    localparam int IW = (n > 1) ? $clog2(n) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [n-1:0]  a, b;
    logic          carry;
    logic          sign;
    logic [IW-1:0] cnt;

    logic          last;
    logic          sum_bit;
    logic          carry_out;
    logic          ovf_next;

    // Subtraction is two's complement: inverted magnitude plus a carry-in of 1.
    always_comb begin
        last      = (cnt == IW'(n - 1));
        sum_bit   = a[cnt] ^ b[cnt] ^ carry;
        carry_out = (a[cnt] & b[cnt]) | (a[cnt] & carry) | (b[cnt] & carry);
        ovf_next  = sign ? ~carry_out : carry_out;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = ADD;
            end
            ADD: begin
                if (last) state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a     <= '0;
            b     <= '0;
            carry <= 1'b0;
            sign  <= 1'b0;
            cnt   <= '0;
            X     <= '0;
            ovf   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a     <= Y;
                        b     <= neg ? ~Res : Res;
                        carry <= neg;
                        sign  <= neg;
                        cnt   <= '0;
                    end
                end
                ADD: begin
                    carry <= carry_out;
                    cnt   <= cnt + 1'b1;
                    if (last) begin
                        ovf <= ovf_next;
`ifdef SIGNMAG_ADD_SAT_EN
                        if (ovf_next) X <= sign ? '0 : '1;
                        else          X[cnt] <= sum_bit;
`else
                        X[cnt] <= sum_bit;
`endif
                    end else begin
                        X[cnt] <= sum_bit;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_signmag_add.sv
// Directed self-checking bench for signmag_add (n=4); expectations follow SIGNMAG_ADD_SAT_EN if defined.
module tb_signmag_add;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] Res;
    logic       neg;
    logic [3:0] Y;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] X;
    logic       ovf;

    int unsigned n_checks;
    int unsigned n_fail;

    signmag_add #(.n(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Res       (Res),
        .neg       (neg),
        .Y         (Y),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .X         (X),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Accept one operand set, scramble inputs during ADD, then check latency and result.
    task automatic do_op(input logic [3:0] r, input logic ng, input logic [3:0] y,
                         input logic [3:0] ex, input logic eo, input logic handoff);
        Res = r; neg = ng; Y = y; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        Res = 4'($urandom); neg = 1'($urandom); Y = 4'($urandom);
        for (int i = 1; i < 4; i++) begin
            step();
            check("busy_out_valid", out_valid, 0);
            check("busy_in_ready", in_ready, 0);
        end
        step();
        check("done_out_valid", out_valid, 1);
        check("done_X", X, ex);
        check("done_ovf", ovf, eo);
        if (handoff) begin
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            check("handoff_in_ready", in_ready, 1);
            check("handoff_out_valid", out_valid, 0);
        end
    endtask

    logic [3:0] x_ovf_add, x_ovf_sub;

    initial begin
        n_checks = 0;
        n_fail   = 0;
`ifdef SIGNMAG_ADD_SAT_EN
        x_ovf_add = 4'd15;
        x_ovf_sub = 4'd0;
`else
        x_ovf_add = 4'd2;
        x_ovf_sub = 4'd12;
`endif
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        Res = '0; neg = 1'b0; Y = '0;
        step();
        step();
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_X", X, 0);
        check("rst_ovf", ovf, 0);

        do_op(4'd3, 1'b0, 4'd5, 4'd8, 1'b0, 1'b1);
        do_op(4'd3, 1'b1, 4'd5, 4'd2, 1'b0, 1'b1);
        do_op(4'd0, 1'b1, 4'd7, 4'd7, 1'b0, 1'b1);
        do_op(4'd9, 1'b0, 4'd9, x_ovf_add, 1'b1, 1'b1);
        do_op(4'd6, 1'b1, 4'd2, x_ovf_sub, 1'b1, 1'b1);
        do_op(4'd15, 1'b1, 4'd15, 4'd0, 1'b0, 1'b1);

        // Back-pressure: hold in DONE for 5 cycles
        do_op(4'd2, 1'b1, 4'd9, 4'd7, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_X", X, 7);
            check("hold_ovf", ovf, 0);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("hold_release_in_ready", in_ready, 1);

        // Streaming: one accept every n+2 = 6 cycles
        Res = 4'd3; neg = 1'b0; Y = 4'd5; in_valid = 1'b1; out_ready = 1'b1;
        step();
        for (int i = 1; i <= 10; i++) begin
            step();
            check("stream_out_valid", out_valid, (i == 4 || i == 10) ? 1 : 0);
            check("stream_in_ready", in_ready, (i == 5) ? 1 : 0);
            if (i == 4 || i == 10) check("stream_X", X, 8);
        end
        in_valid = 1'b0;
        step();
        check("stream_end_in_ready", in_ready, 1);
        out_ready = 1'b0;

        // Reset during the 2nd ADD cycle, with in_valid/out_ready also high
        Res = 4'd1; neg = 1'b0; Y = 4'd4; in_valid = 1'b1;
        step();
        step();
        rst_n = 1'b0; out_ready = 1'b1;
        step();
        rst_n = 1'b1; in_valid = 1'b0;
        check("midrst_in_ready", in_ready, 1);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_X", X, 0);
        check("midrst_ovf", ovf, 0);
        for (int i = 0; i < 6; i++) begin
            step();
            check("midrst_no_result", out_valid, 0);
        end
        out_ready = 1'b0;

        do_op(4'd4, 1'b0, 4'd1, 4'd5, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
